// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg : shared types and constants for the audio event scheduler
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package audio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [1:0] TSEL_NONE  = 2'd0;
  localparam logic [1:0] TSEL_MATCH = 2'd1;
  localparam logic [1:0] TSEL_KEY   = 2'd2;
  localparam logic [1:0] TSEL_HALT  = 2'd3;

  localparam logic [16:0] DEF_MATCH_HP = 17'd56818;
  localparam logic [16:0] DEF_KEY_HP   = 17'd28409;
  localparam logic [16:0] DEF_HALT_HP  = 17'd113636;

  // Fixed priority: halt > match > key.
  function automatic logic [1:0] pick_sel(input logic halt, input logic match, input logic key);
    if (halt)       return TSEL_HALT;
    else if (match) return TSEL_MATCH;
    else if (key)   return TSEL_KEY;
    else            return TSEL_NONE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect : rising-edge pulse from a level input via one delay register
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_sig,
  output logic pulse
);

  logic in_q;

  // Clearing the delay register on reset makes an input that is already high
  // at release register as an edge on the first clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) in_q <= 1'b0;
    else       in_q <= in_sig;
  end

  assign pulse = in_sig & ~in_q;

endmodule

`default_nettype wire

// File: rtl/audio_event_scheduler.sv
// ---------------------------------------------------------------------------
// audio_event_scheduler : queues match/halt/key events into separated beeps
// Revision              : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module audio_event_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned TONE_CYCLES = 5000000,
  parameter int unsigned GAP_CYCLES  = 1000000,
  parameter int unsigned HALT_REPEAT = 3,
  parameter logic [16:0] MATCH_HP    = DEF_MATCH_HP,
  parameter logic [16:0] KEY_HP      = DEF_KEY_HP,
  parameter logic [16:0] HALT_HP     = DEF_HALT_HP
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        match_evt,
  input  logic        halt_evt,
  input  logic        key_evt,
  output logic        tone_en,
  output logic [16:0] half_period,
  output logic [1:0]  tone_sel,
  output logic        busy,
  output logic [3:0]  match_pending,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned CNT_MAX = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
  localparam int          CW      = $clog2(CNT_MAX) + 1;

  logic match_ev, halt_ev, key_ev;

  edge_detect u_match_edge (.clk(clk), .reset(reset), .in_sig(match_evt), .pulse(match_ev));
  edge_detect u_halt_edge  (.clk(clk), .reset(reset), .in_sig(halt_evt),  .pulse(halt_ev));
  edge_detect u_key_edge   (.clk(clk), .reset(reset), .in_sig(key_evt),   .pulse(key_ev));

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    match_pending_q, match_pending_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          key_pend_q, key_pend_d;
  logic          halt_pend_q, halt_pend_d;
  logic [2:0]    halt_rem_q, halt_rem_d;
  logic          tone_en_q, tone_en_d;
  logic [16:0]   half_period_q, half_period_d;
  logic [1:0]    tone_sel_q, tone_sel_d;
  logic          busy_q, busy_d;

  logic [1:0]    arb_sel;
  logic          launch, go_gap;
  logic          match_deq, key_deq, halt_deq;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    halt_rem_d    = halt_rem_q;
    tone_en_d     = tone_en_q;
    half_period_d = half_period_q;
    tone_sel_d    = tone_sel_q;
    launch        = 1'b0;
    go_gap        = 1'b0;
    match_deq     = 1'b0;
    key_deq       = 1'b0;
    halt_deq      = 1'b0;
    arb_sel       = pick_sel(halt_pend_q, match_pending_q != 4'd0, key_pend_q);

    case (state_q)
      IDLE: launch = (arb_sel != TSEL_NONE);
      TONE: begin
        // A pending halt cuts short any non-halt tone; the lost tone is not re-queued.
        if ((halt_pend_q && tone_sel_q != TSEL_HALT) || cnt_q == '0) go_gap = 1'b1;
        else                                                         cnt_d  = cnt_q - 1'b1;
      end
      GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (halt_rem_q != 3'd0) begin
          halt_rem_d    = halt_rem_q - 3'd1;
          state_d       = TONE;
          cnt_d         = CW'(TONE_CYCLES - 1);
          tone_en_d     = 1'b1;
          tone_sel_d    = TSEL_HALT;
          half_period_d = HALT_HP;
        end else if (arb_sel != TSEL_NONE) begin
          launch = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      state_d    = TONE;
      cnt_d      = CW'(TONE_CYCLES - 1);
      tone_en_d  = 1'b1;
      tone_sel_d = arb_sel;
      case (arb_sel)
        TSEL_HALT: begin
          half_period_d = HALT_HP;
          halt_deq      = 1'b1;
          halt_rem_d    = 3'(HALT_REPEAT - 1);
        end
        TSEL_MATCH: begin
          half_period_d = MATCH_HP;
          match_deq     = 1'b1;
        end
        default: begin
          half_period_d = KEY_HP;
          key_deq       = 1'b1;
        end
      endcase
    end

    if (go_gap) begin
      state_d       = GAP;
      cnt_d         = CW'(GAP_CYCLES - 1);
      tone_en_d     = 1'b0;
      tone_sel_d    = TSEL_NONE;
      half_period_d = 17'd0;
    end

    busy_d = (state_d != IDLE);

    // Simultaneous enqueue and dequeue nets to no change and never drops.
    match_pending_d = match_pending_q;
    drop_cnt_d      = drop_cnt_q;
    if (match_ev && !match_deq) begin
      if (match_pending_q == 4'd15) begin
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end else begin
        match_pending_d = match_pending_q + 4'd1;
      end
    end else if (!match_ev && match_deq) begin
      match_pending_d = match_pending_q - 4'd1;
    end

    key_pend_d  = (key_pend_q & ~key_deq) | key_ev;
    halt_pend_d = (halt_pend_q & ~halt_deq) | (halt_ev & (halt_rem_q == 3'd0));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      match_pending_q <= 4'd0;
      drop_cnt_q      <= 8'd0;
      key_pend_q      <= 1'b0;
      halt_pend_q     <= 1'b0;
      halt_rem_q      <= 3'd0;
      tone_en_q       <= 1'b0;
      half_period_q   <= 17'd0;
      tone_sel_q      <= TSEL_NONE;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      match_pending_q <= match_pending_d;
      drop_cnt_q      <= drop_cnt_d;
      key_pend_q      <= key_pend_d;
      halt_pend_q     <= halt_pend_d;
      halt_rem_q      <= halt_rem_d;
      tone_en_q       <= tone_en_d;
      half_period_q   <= half_period_d;
      tone_sel_q      <= tone_sel_d;
      busy_q          <= busy_d;
    end
  end

  assign tone_en       = tone_en_q;
  assign half_period   = half_period_q;
  assign tone_sel      = tone_sel_q;
  assign busy          = busy_q;
  assign match_pending = match_pending_q;
  assign drop_cnt      = drop_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_event_scheduler.sv
// ---------------------------------------------------------------------------
// tb_audio_event_scheduler : directed stimulus with a tone scoreboard
// Revision                 : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_audio_event_scheduler;

  logic        clk       = 1'b0;
  logic        reset     = 1'b1;
  logic        match_evt = 1'b0;
  logic        halt_evt  = 1'b0;
  logic        key_evt   = 1'b0;
  logic        tone_en;
  logic [16:0] half_period;
  logic [1:0]  tone_sel;
  logic        busy;
  logic [3:0]  match_pending;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int tones_seen = 0;

  typedef struct {
    logic [1:0]  sel;
    logic [16:0] hp;
    int          len;
  } tone_t;

  tone_t exp_q[$];

  always #5 clk = ~clk;

  audio_event_scheduler #(
    .TONE_CYCLES(8),
    .GAP_CYCLES (4),
    .HALT_REPEAT(3)
  ) u_dut (
    .clk          (clk),
    .reset        (reset),
    .match_evt    (match_evt),
    .halt_evt     (halt_evt),
    .key_evt      (key_evt),
    .tone_en      (tone_en),
    .half_period  (half_period),
    .tone_sel     (tone_sel),
    .busy         (busy),
    .match_pending(match_pending),
    .drop_cnt     (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] sel, input logic [16:0] hp, input int len);
    tone_t t;
    t.sel = sel;
    t.hp  = hp;
    t.len = len;
    exp_q.push_back(t);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    tick(3);
    while (busy && n < budget) begin
      tick();
      n++;
    end
    tick(3);
    chk("idle_reached", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  // Monitor: pops one expectation per tone start, checks pitch, length and gap.
  logic  mon_prev   = 1'b0;
  bit    mon_have   = 1'b0;
  bit    mon_in_gap = 1'b0;
  int    mon_len    = 0;
  int    mon_gap    = 0;
  tone_t mon_cur;

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mon_prev   = 1'b0;
        mon_have   = 1'b0;
        mon_in_gap = 1'b0;
        mon_len    = 0;
      end else begin
        if (tone_en && !mon_prev) begin
          tones_seen++;
          if (mon_in_gap) chk("gap_len", mon_gap, 4);
          mon_in_gap = 1'b0;
          mon_len    = 1;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            mon_have = 1'b0;
            $display("FAIL unexpected_tone: got sel %0d hp %0d expected no tone at %0t",
                     tone_sel, half_period, $time);
          end else begin
            mon_cur  = exp_q.pop_front();
            mon_have = 1'b1;
            chk("tone_sel", tone_sel, mon_cur.sel);
            chk("half_period", half_period, mon_cur.hp);
          end
        end else if (tone_en) begin
          mon_len++;
        end else if (mon_prev) begin
          if (mon_have) chk("tone_len", mon_len, mon_cur.len);
          chk("gap_outputs", {tone_sel, half_period}, 0);
          chk("gap_busy", busy, 1);
          mon_have   = 1'b0;
          mon_in_gap = 1'b1;
          mon_gap    = 1;
        end else if (mon_in_gap) begin
          if (busy) mon_gap++;
          else      mon_in_gap = 1'b0;
        end
        mon_prev = tone_en;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int tones_before;

    // Reset state
    tick(2);
    chk("rst_tone_en", tone_en, 0);
    chk("rst_half_period", half_period, 0);
    chk("rst_tone_sel", tone_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_match_pending", match_pending, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    reset = 1'b0;
    tick();

    // Single match pulse: two-clock latency, 8 tone clocks, 4 gap clocks
    push(2'd1, 17'd56818, 8);
    match_evt = 1'b1;
    tick();
    chk("c1_pending_after_edge", match_pending, 1);
    chk("c1_tone_not_yet", tone_en, 0);
    chk("c1_busy_not_yet", busy, 0);
    match_evt = 1'b0;
    tick();
    chk("c1_tone_on", tone_en, 1);
    chk("c1_busy_on", busy, 1);
    chk("c1_pending_dequeued", match_pending, 0);
    tick(7);
    chk("c1_tone_last_clock", tone_en, 1);
    tick();
    chk("c1_tone_off", tone_en, 0);
    chk("c1_gap_busy", busy, 1);
    tick(3);
    chk("c1_gap_end_busy", busy, 1);
    tick();
    chk("c1_idle_busy", busy, 0);
    wait_idle(50);

    // Key and match on the same clock: match first, then key
    push(2'd1, 17'd56818, 8);
    push(2'd2, 17'd28409, 8);
    match_evt = 1'b1;
    key_evt   = 1'b1;
    tick();
    chk("c2_match_pending", match_pending, 1);
    match_evt = 1'b0;
    key_evt   = 1'b0;
    tick();
    chk("c2_first_sel", tone_sel, 1);
    chk("c2_match_dequeued", match_pending, 0);
    wait_idle(100);

    // 24 match pulses two clocks apart: queue saturates, 5 dropped, 19 tones
    for (int i = 0; i < 19; i++) push(2'd1, 17'd56818, 8);
    for (int i = 0; i < 24; i++) begin
      match_evt = 1'b1;
      tick();
      match_evt = 1'b0;
      tick();
      if (i == 17) begin
        chk("c3_pending_full", match_pending, 15);
        chk("c3_no_drop_yet", drop_cnt, 0);
      end
    end
    chk("c3_pending_sat", match_pending, 15);
    chk("c3_drop_cnt", drop_cnt, 5);
    wait_idle(400);
    chk("c3_pending_empty", match_pending, 0);
    chk("c3_drop_kept", drop_cnt, 5);

    // Halt during a match tone: match cut to 4 clocks, then a 3-beep burst
    push(2'd1, 17'd56818, 4);
    push(2'd3, 17'd113636, 8);
    push(2'd3, 17'd113636, 8);
    push(2'd3, 17'd113636, 8);
    match_evt = 1'b1;
    tick();
    match_evt = 1'b0;
    tick(3);
    halt_evt = 1'b1;
    tick();
    halt_evt = 1'b0;
    chk("c4_tone_still_on", tone_en, 1);
    tick();
    chk("c4_aborted", tone_en, 0);
    chk("c4_abort_busy", busy, 1);
    tick(4);
    chk("c4_halt_sel", tone_sel, 3);
    tick(2);
    halt_evt = 1'b1;
    tick();
    halt_evt = 1'b0;
    wait_idle(150);

    // Reset asserted mid-tone clears everything before the next clock
    push(2'd1, 17'd56818, 8);
    match_evt = 1'b1;
    tick();
    match_evt = 1'b0;
    tick();
    match_evt = 1'b1;
    tick();
    match_evt = 1'b0;
    tick();
    chk("c5_tone_before_reset", tone_en, 1);
    chk("c5_pending_before_reset", match_pending, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("c5_rst_tone_en", tone_en, 0);
    chk("c5_rst_busy", busy, 0);
    chk("c5_rst_pending", match_pending, 0);
    chk("c5_rst_drop_cnt", drop_cnt, 0);
    chk("c5_rst_sel", tone_sel, 0);
    tick(2);
    reset = 1'b0;
    tones_before = tones_seen;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tone_en || busy) chk("c5_silent", {tone_en, busy}, 0);
    end
    chk("c5_no_tone", tones_seen, tones_before);
    chk("c5_busy_low", busy, 0);
    chk("c5_queue_drained", exp_q.size(), 0);

    // Level held high for 100 clocks gives exactly one beep
    tones_before = tones_seen;
    push(2'd1, 17'd56818, 8);
    match_evt = 1'b1;
    tick(100);
    match_evt = 1'b0;
    wait_idle(50);
    chk("c6_one_beep", tones_seen, tones_before + 1);

    chk("total_tones", tones_seen, 28);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
